// File: rtl/tt_io_pkg.sv
// Shared state encoding and io_in bit layout for the tile I/O driver.
package tt_io_pkg;
    localparam int IO_W   = 8;
    localparam int IO_CLK = 0;
    localparam int IO_RST = 1;
    localparam int IO_EN  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [IO_W-1:0] IO_IDLE = 8'h02;

    function automatic logic [IO_W-1:0] io_word(input logic tclk, input logic trst, input logic ten);
        logic [IO_W-1:0] w;
        w         = '0;
        w[IO_CLK] = tclk;
        w[IO_RST] = trst;
        w[IO_EN]  = ten;
        return w;
    endfunction
endpackage

// File: rtl/tt_io_driver_if.sv
// Valid/ready sample stream from the tile I/O driver to its consumer.
interface tt_io_driver_if;
    import tt_io_pkg::*;

    logic [IO_W-1:0] smp_data;
    logic            smp_valid;
    logic            smp_ready;

    modport master (output smp_data, output smp_valid, input smp_ready);
    modport slave  (input smp_data, input smp_valid, output smp_ready);
endinterface

// File: rtl/tt_sample_fifo.sv
// First-word fall-through FIFO holding tile samples until the sink takes them.
module tt_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/tt_io_driver.sv
// Host-side tile I/O driver: generates tile clock/reset/enable and streams io_out samples.
// Build option TT_IO_DRIVER_FIFO_EN swaps the single sample register for a 4-entry FIFO.
//
// state | meaning
// IDLE  | tile held in reset, clock low, waiting for start
// RESET | tile clock running, tile reset high for RST_CYCLES periods
// RUN   | tile enabled, one io_out sample per tile-clock period
// DONE  | one-cycle done pulse, tile back in reset
module tt_io_driver
    import tt_io_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 8,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] run_len,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [IO_W-1:0]  io_in,
    input  logic [IO_W-1:0]  io_out,
    tt_io_driver_if.master   smp
);
    localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d, next_phase;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [IO_W-1:0]  io_in_q, io_in_d;
    logic             ph_wrap, next_clk, tclk_fall, sample_now;
    logic             ovf_clr, ovf_set, pop;

    assign ph_wrap    = (phase_q == PH_W'(CLK_DIV - 1));
    assign tclk_fall  = ph_wrap & io_in_q[IO_CLK];
    assign sample_now = (state_q == RUN) & tclk_fall;
    assign next_clk   = io_in_q[IO_CLK] ^ ph_wrap;
    assign next_phase = ph_wrap ? '0 : phase_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        rst_cnt_d = rst_cnt_q;
        len_d     = len_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        io_in_d   = io_in_q;
        ovf_clr   = 1'b0;
        case (state_q)
            RESET: begin
                phase_d = next_phase;
                io_in_d = io_word(next_clk, 1'b1, 1'b0);
                if (tclk_fall) begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                    if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                        if (len_q == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            io_in_d = IO_IDLE;
                        end else begin
                            state_d = RUN;
                            io_in_d = io_word(1'b0, 1'b0, 1'b1);
                        end
                    end
                end
            end
            RUN: begin
                phase_d = next_phase;
                io_in_d = io_word(next_clk, 1'b0, 1'b1);
                if (tclk_fall) begin
                    len_d = len_q - 1'b1;
                    if (len_q == LEN_W'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        io_in_d = IO_IDLE;
                    end
                end
            end
            default: begin
                // IDLE and DONE behave alike; busy is already low in DONE
                state_d = IDLE;
                phase_d = '0;
                busy_d  = 1'b0;
                io_in_d = IO_IDLE;
                if (start) begin
                    state_d   = RESET;
                    busy_d    = 1'b1;
                    len_d     = run_len;
                    rst_cnt_d = '0;
                    ovf_clr   = 1'b1;
                end
            end
        endcase
        ovf_d = ovf_clr ? 1'b0 : (ovf_q | ovf_set);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            rst_cnt_q <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            io_in_q   <= IO_IDLE;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            rst_cnt_q <= rst_cnt_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            io_in_q   <= io_in_d;
        end
    end

    assign pop = smp.smp_valid & smp.smp_ready;

`ifdef TT_IO_DRIVER_FIFO_EN
    logic            fifo_full, fifo_empty;
    logic [IO_W-1:0] fifo_rdata;

    tt_sample_fifo #(
        .DEPTH (4),
        .W     (IO_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sample_now),
        .wdata (io_out),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ovf_set       = sample_now & fifo_full & ~pop;
    assign smp.smp_data  = fifo_rdata;
    assign smp.smp_valid = ~fifo_empty;
`else
    logic [IO_W-1:0] smp_data_q, smp_data_d;
    logic            smp_valid_q, smp_valid_d;

    always_comb begin
        smp_data_d  = smp_data_q;
        smp_valid_d = smp_valid_q;
        if (sample_now && (!smp_valid_q || smp.smp_ready)) begin
            smp_data_d  = io_out;
            smp_valid_d = 1'b1;
        end else if (pop) begin
            smp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            smp_data_q  <= '0;
            smp_valid_q <= 1'b0;
        end else begin
            smp_data_q  <= smp_data_d;
            smp_valid_q <= smp_valid_d;
        end
    end

    // an unconsumed sample is kept; the newcomer is the one lost
    assign ovf_set       = sample_now & smp_valid_q & ~smp.smp_ready;
    assign smp.smp_data  = smp_data_q;
    assign smp.smp_valid = smp_valid_q;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign io_in    = io_in_q;
endmodule
